// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: owns HI/LO, models the fixed MDU latency
// with a down-counter and raises the D-stage stall while a result is in flight.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_op_E,
  input  logic [31:0] rs_data_E,
  input  logic [31:0] rt_data_E,
  input  logic        md_use_D,
  output logic        busy,
  output logic        start,
  output logic        mdu_stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      w_state;
  logic [3:0]  r_count, w_count_nxt;
  logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic [31:0] w_hi_nxt, w_lo_nxt, w_pend_hi_nxt, w_pend_lo_nxt;
  logic        r_pend_vld, w_pend_vld_nxt;

  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_rs_mag, w_rt_mag, w_sdivisor, w_udivisor;
  logic [31:0] w_sq, w_sr, w_uq, w_ur, w_q_s, w_r_s;
  logic        w_div_zero;

  assign w_prod_s = $signed({{32{rs_data_E[31]}}, rs_data_E}) *
                    $signed({{32{rt_data_E[31]}}, rt_data_E});
  assign w_prod_u = {32'd0, rs_data_E} * {32'd0, rt_data_E};

  // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign w_div_zero = (rt_data_E == 32'd0);
  assign w_rs_mag   = rs_data_E[31] ? (~rs_data_E + 32'd1) : rs_data_E;
  assign w_rt_mag   = rt_data_E[31] ? (~rt_data_E + 32'd1) : rt_data_E;
  assign w_sdivisor = w_div_zero ? 32'd1 : w_rt_mag;
  assign w_udivisor = w_div_zero ? 32'd1 : rt_data_E;
  assign w_sq       = w_rs_mag / w_sdivisor;
  assign w_sr       = w_rs_mag % w_sdivisor;
  assign w_uq       = rs_data_E / w_udivisor;
  assign w_ur       = rs_data_E % w_udivisor;
  assign w_q_s      = (rs_data_E[31] ^ rt_data_E[31]) ? (~w_sq + 32'd1) : w_sq;
  assign w_r_s      = rs_data_E[31] ? (~w_sr + 32'd1) : w_sr;

  assign w_state   = (r_count != 4'd0) ? S_BUSY : S_IDLE;
  assign busy      = (w_state == S_BUSY);
  assign start     = (mdu_op_E >= OP_MULT) && (mdu_op_E <= OP_DIVU) && !busy;
  assign mdu_stall = md_use_D && (busy || start);
  assign hi_out    = r_hi;
  assign lo_out    = r_lo;

  always_comb begin
    w_count_nxt    = r_count;
    w_hi_nxt       = r_hi;
    w_lo_nxt       = r_lo;
    w_pend_hi_nxt  = r_pend_hi;
    w_pend_lo_nxt  = r_pend_lo;
    w_pend_vld_nxt = r_pend_vld;
    if (w_state == S_BUSY) begin
      // Ops arriving here, including on the commit edge, are dropped.
      w_count_nxt = r_count - 4'd1;
      if (r_count == 4'd1 && r_pend_vld) begin
        w_hi_nxt = r_pend_hi;
        w_lo_nxt = r_pend_lo;
      end
    end else begin
      case (mdu_op_E)
        OP_MULT: begin
          {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_s;
          w_pend_vld_nxt = 1'b1;
          w_count_nxt    = MULT_CNT;
        end
        OP_MULTU: begin
          {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_u;
          w_pend_vld_nxt = 1'b1;
          w_count_nxt    = MULT_CNT;
        end
        OP_DIV: begin
          w_pend_hi_nxt  = w_r_s;
          w_pend_lo_nxt  = w_q_s;
          w_pend_vld_nxt = !w_div_zero;
          w_count_nxt    = DIV_CNT;
        end
        OP_DIVU: begin
          w_pend_hi_nxt  = w_ur;
          w_pend_lo_nxt  = w_uq;
          w_pend_vld_nxt = !w_div_zero;
          w_count_nxt    = DIV_CNT;
        end
        OP_MTHI: w_hi_nxt = rs_data_E;
        OP_MTLO: w_lo_nxt = rs_data_E;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count    <= 4'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_pend_hi  <= 32'd0;
      r_pend_lo  <= 32'd0;
      r_pend_vld <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_hi       <= w_hi_nxt;
      r_lo       <= w_lo_nxt;
      r_pend_hi  <= w_pend_hi_nxt;
      r_pend_lo  <= w_pend_lo_nxt;
      r_pend_vld <= w_pend_vld_nxt;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized self-checking bench for mdu_ctrl against a 64-bit arithmetic model.
module tb_mdu_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] rs, rt;
  logic        md_use_D;
  logic        busy, start, mdu_stall;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int failures = 0;
  logic [31:0] mhi, mlo;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .mdu_op_E(op), .rs_data_E(rs), .rt_data_E(rt),
    .md_use_D(md_use_D), .busy(busy), .start(start), .mdu_stall(mdu_stall),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  // Returns {HI,LO} after the op completes, given the current HI/LO.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = {h, l};
    case (o)
      4'd1: p = sa * sb;
      4'd2: p = ua * ub;
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
      4'd4: if (b != 0) begin uq = ua / ub; ur = ua % ub; p = {ur[31:0], uq[31:0]}; end
      4'd5: p = {a, l};
      4'd6: p = {h, a};
      default: ;
    endcase
    return p;
  endfunction

  // Drives one accepted op, then counts busy cycles (bounded).
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    @(negedge clk); op = o; rs = a; rt = b;
    @(negedge clk); op = 4'd0; rs = $urandom; rt = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 20) begin n++; @(negedge clk); end
  endtask

  task automatic do_mt(input logic [3:0] o, input logic [31:0] a);
    @(negedge clk); op = o; rs = a;
    @(negedge clk); op = 4'd0;
  endtask

  task automatic test_reset;
    reset = 1'b0; op = 4'd0; rs = 0; rt = 0; md_use_D = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (hi_out !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi_out); end
    checks++; if (lo_out !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo_out); end
    op = 4'd1; md_use_D = 1'b1; #1;
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL reset_start got=%b exp=1", start); end
    checks++; if (mdu_stall !== 1'b1) begin failures++; $display("FAIL reset_stall got=%b exp=1", mdu_stall); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_hold_busy got=%b exp=0", busy); end
    op = 4'd0; md_use_D = 1'b0; reset = 1'b1;
    mhi = 0; mlo = 0;
  endtask

  task automatic test_mult;
    int n;
    run_op(4'd1, 32'h7FFFFFFF, 32'h00000002, n);
    checks++; if (n != 5) begin failures++; $display("FAIL mult_busy got=%0d exp=5", n); end
    checks++; if ({hi_out, lo_out} !== 64'h00000000_FFFFFFFE) begin failures++; $display("FAIL mult_res got=%h_%h exp=00000000_fffffffe", hi_out, lo_out); end
    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
    checks++; if (n != 5) begin failures++; $display("FAIL multu_busy got=%0d exp=5", n); end
    checks++; if ({hi_out, lo_out} !== 64'hFFFFFFFE_00000001) begin failures++; $display("FAIL multu_res got=%h_%h exp=fffffffe_00000001", hi_out, lo_out); end
    mhi = hi_out; mlo = lo_out;
  endtask

  task automatic test_div;
    int n;
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, n);
    checks++; if (n != 10) begin failures++; $display("FAIL div_busy got=%0d exp=10", n); end
    checks++; if ({hi_out, lo_out} !== 64'hFFFFFFFF_FFFFFFFD) begin failures++; $display("FAIL div_res got=%h_%h exp=ffffffff_fffffffd", hi_out, lo_out); end
    run_op(4'd4, 32'hFFFFFFF9, 32'd2, n);
    checks++; if ({hi_out, lo_out} !== 64'h00000001_7FFFFFFC) begin failures++; $display("FAIL divu_res got=%h_%h exp=00000001_7ffffffc", hi_out, lo_out); end
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, n);
    checks++; if ({hi_out, lo_out} !== 64'h00000000_80000000) begin failures++; $display("FAIL div_ovf got=%h_%h exp=00000000_80000000", hi_out, lo_out); end
    mhi = hi_out; mlo = lo_out;
  endtask

  task automatic test_mt_div0;
    int n;
    do_mt(4'd5, 32'h1234);
    checks++; if (hi_out !== 32'h1234) begin failures++; $display("FAIL mthi got=%h exp=00001234", hi_out); end
    do_mt(4'd6, 32'h5678);
    checks++; if (lo_out !== 32'h5678) begin failures++; $display("FAIL mtlo got=%h exp=00005678", lo_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mt_busy got=%b exp=0", busy); end
    run_op(4'd3, 32'hDEAD, 32'd0, n);
    checks++; if (n != 10) begin failures++; $display("FAIL div0_busy got=%0d exp=10", n); end
    checks++; if ({hi_out, lo_out} !== 64'h00001234_00005678) begin failures++; $display("FAIL div0_res got=%h_%h exp=00001234_00005678", hi_out, lo_out); end
    mhi = 32'h1234; mlo = 32'h5678;
  endtask

  task automatic test_stall;
    int n;
    logic [63:0] e;
    @(negedge clk); op = 4'd1; rs = 32'd3; rt = 32'd5; md_use_D = 1'b1; #1;
    checks++; if (mdu_stall !== 1'b1) begin failures++; $display("FAIL stall_start got=%b exp=1", mdu_stall); end
    @(negedge clk); op = 4'd0; n = 0;
    while (busy === 1'b1 && n < 20) begin
      checks++; if (mdu_stall !== 1'b1) begin failures++; $display("FAIL stall_busy got=%b exp=1 cyc=%0d", mdu_stall, n); end
      n++; @(negedge clk);
    end
    checks++; if (n != 5) begin failures++; $display("FAIL stall_len got=%0d exp=5", n); end
    checks++; if (mdu_stall !== 1'b0) begin failures++; $display("FAIL stall_after got=%b exp=0", mdu_stall); end
    checks++; if ({hi_out, lo_out} !== 64'd15) begin failures++; $display("FAIL stall_res got=%h_%h exp=0_f", hi_out, lo_out); end
    mhi = 0; mlo = 15;
    e = model(4'd2, 32'hABCD0123, 32'h00FF00FF, mhi, mlo);
    @(negedge clk); op = 4'd2; rs = 32'hABCD0123; rt = 32'h00FF00FF; md_use_D = 1'b0; #1;
    checks++; if (mdu_stall !== 1'b0) begin failures++; $display("FAIL nostall_start got=%b exp=0", mdu_stall); end
    @(negedge clk); op = 4'd0; n = 0;
    while (busy === 1'b1 && n < 20) begin
      checks++; if (mdu_stall !== 1'b0) begin failures++; $display("FAIL nostall_busy got=%b exp=0", mdu_stall); end
      n++; @(negedge clk);
    end
    checks++; if ({hi_out, lo_out} !== e) begin failures++; $display("FAIL nostall_res got=%h_%h exp=%h", hi_out, lo_out, e); end
    mhi = e[63:32]; mlo = e[31:0];
  endtask

  task automatic test_ignore;
    int n;
    logic [63:0] e;
    e = model(4'd1, 32'hFFFF1234, 32'h00007777, mhi, mlo);
    @(negedge clk); op = 4'd1; rs = 32'hFFFF1234; rt = 32'h00007777;
    @(negedge clk); n = 0;
    while (busy === 1'b1 && n < 20) begin
      op = 4'd1; rs = $urandom; rt = $urandom | 32'd1; #1;
      checks++; if (start !== 1'b0) begin failures++; $display("FAIL ignore_start got=%b exp=0", start); end
      n++; @(negedge clk);
    end
    op = 4'd0;
    checks++; if (n != 5) begin failures++; $display("FAIL ignore_len got=%0d exp=5", n); end
    checks++; if ({hi_out, lo_out} !== e) begin failures++; $display("FAIL ignore_res got=%h_%h exp=%h", hi_out, lo_out, e); end
    mhi = e[63:32]; mlo = e[31:0];
  endtask

  task automatic test_reset_mid;
    @(negedge clk); op = 4'd3; rs = 32'd1000; rt = 32'd7;
    @(negedge clk); op = 4'd0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if ({hi_out, lo_out} !== 64'd0) begin failures++; $display("FAIL rmid_clr got=%h_%h exp=0", hi_out, lo_out); end
    repeat (12) @(negedge clk);
    checks++; if ({busy, hi_out, lo_out} !== 65'd0) begin failures++; $display("FAIL rmid_late got=%b %h_%h exp=0", busy, hi_out, lo_out); end
    mhi = 0; mlo = 0;
  endtask

  task automatic test_random;
    int n;
    logic [3:0] o;
    logic [31:0] a, b;
    logic [63:0] e;
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if ($urandom_range(0, 3) == 0) b = b & 32'hF;
      e = model(o, a, b, mhi, mlo);
      if (o >= 4'd1 && o <= 4'd4) begin
        run_op(o, a, b, n);
        checks++; if (n != ((o <= 4'd2) ? 5 : 10)) begin failures++; $display("FAIL rnd_len op=%0d got=%0d", o, n); end
      end else begin
        @(negedge clk); op = o; rs = a; rt = b; md_use_D = 1'($urandom); #1;
        checks++; if (mdu_stall !== 1'b0) begin failures++; $display("FAIL rnd_stall op=%0d got=%b exp=0", o, mdu_stall); end
        @(negedge clk); op = 4'd0; md_use_D = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rnd_busy op=%0d got=%b exp=0", o, busy); end
      end
      checks++; if ({hi_out, lo_out} !== e) begin failures++; $display("FAIL rnd_res op=%0d a=%h b=%h got=%h_%h exp=%h", o, a, b, hi_out, lo_out, e); end
      mhi = e[63:32]; mlo = e[31:0];
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_mt_div0;
    test_stall;
    test_ignore;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
